mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester (fetch = 0, data = 1) arbiter in front of a single
//   16-bit memory port. A single transaction is in flight at a time:
//   IDLE -> ISSUE -> [WAIT] -> DONE -> IDLE.
//   Reads that see no mem_rd_done within RD_TIMEOUT WAIT cycles complete
//   with req_err set and zero read data.
//
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//                          between the requesters. When undefined, data
//                          (index 1) always wins over fetch (index 0).
//
//   All outputs are registered. busy is decoded from the state register.
module mem_port_arbiter #(
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_en      [0:1],
    input  logic        req_wr      [0:1],
    input  logic [14:0] req_addr    [0:1],
    input  logic [1:0]  req_byte_en [0:1],
    input  logic [15:0] req_wr_data [0:1],
    output logic        req_done    [0:1],
    output logic        req_err     [0:1],
    output logic [15:0] req_rd_data [0:1],

    output logic        mem_en,
    output logic [1:0]  mem_wr_en,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wr_data,
    input  logic        mem_rd_done,
    input  logic [15:0] mem_rd_data,

    output logic        busy,
    output logic        grant
);

    // Timeout counter is at least 5 bits and wide enough to hold RD_TIMEOUT.
    localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 5) ? $clog2(RD_TIMEOUT + 1) : 5;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // Latched copy of the winning request
    logic               r_grant;
    logic               r_wr;

    // Timeout and completion bookkeeping
    logic [CNT_W-1:0]   r_cnt;
    logic               w_any_req;
    logic               w_winner;
    logic               w_rd_hit;
    logic               w_timeout;

    // Registered outputs
    logic               r_mem_en;
    logic [1:0]         r_mem_wr_en;
    logic [14:0]        r_mem_addr;
    logic [15:0]        r_mem_wr_data;
    logic               r_req_done    [0:1];
    logic               r_req_err     [0:1];
    logic [15:0]        r_req_rd_data [0:1];

`ifdef ARB_ROUND_ROBIN_EN
    logic               r_rr_last;
`endif

    // Pick the requester to serve when the FSM is idle
    always_comb begin
        w_any_req = req_en[0] | req_en[1];
`ifdef ARB_ROUND_ROBIN_EN
        if (req_en[0] && req_en[1]) begin
            w_winner = ~r_rr_last;
        end else begin
            w_winner = req_en[1];
        end
`else
        w_winner = req_en[1];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and completion qualifiers
    always_comb begin
        w_next_state = r_state;
        w_rd_hit     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_wr) begin
                    w_next_state = ST_DONE;
                end else if (mem_rd_done) begin
                    w_next_state = ST_DONE;
                    w_rd_hit     = 1'b1;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rd_done) begin
                    w_next_state = ST_DONE;
                    w_rd_hit     = 1'b1;
                end else if (r_cnt >= TO_LAST) begin
                    w_next_state = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // WAIT cycle counter: cleared on entry, saturating while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Request latch, memory strobes and per-requester completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant       <= 1'b0;
            r_wr          <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_wr_en   <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_last     <= 1'b0;
`endif
            for (int unsigned i = 0; i < 2; i++) begin
                r_req_done[i]    <= 1'b0;
                r_req_err[i]     <= 1'b0;
                r_req_rd_data[i] <= '0;
            end
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_wr_en <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_req_done[i] <= 1'b0;
                r_req_err[i]  <= 1'b0;
            end

            // Accept: latch the winner and present it to memory during ISSUE
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant       <= w_winner;
                r_wr          <= req_wr[w_winner];
                r_mem_en      <= 1'b1;
                r_mem_addr    <= req_addr[w_winner];
                r_mem_wr_data <= req_wr_data[w_winner];
                r_mem_wr_en   <= req_wr[w_winner] ? req_byte_en[w_winner] : 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                r_rr_last     <= w_winner;
`endif
            end

            // Completion outputs are loaded on entry to DONE so they are
            // visible for exactly the DONE cycle.
            if (r_state != ST_DONE && w_next_state == ST_DONE) begin
                r_req_done[r_grant] <= 1'b1;
                r_req_err[r_grant]  <= w_timeout;
                if (w_rd_hit) begin
                    r_req_rd_data[r_grant] <= mem_rd_data;
                end else if (w_timeout) begin
                    r_req_rd_data[r_grant] <= '0;
                end
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign grant       = r_grant;
    assign mem_en      = r_mem_en;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;

    assign req_done[0]    = r_req_done[0];
    assign req_done[1]    = r_req_done[1];
    assign req_err[0]     = r_req_err[0];
    assign req_err[1]     = r_req_err[1];
    assign req_rd_data[0] = r_req_rd_data[0];
    assign req_rd_data[1] = r_req_rd_data[1];

endmodule
